// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: hazard FSM states, forward-select codes
// and the in-flight destination shadow entry.
package riscv_pipe_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       ld;
    } shadow_t;

    // An entry supplies a source only when it is live and not x0.
    function automatic logic entry_match(input shadow_t e, input logic [4:0] src);
        return e.vld && (e.rd != 5'd0) && (e.rd == src);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one decode source: the youngest in-flight writer wins.
module hazard_fwd_sel
    import riscv_pipe_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       used_i,
    input  shadow_t    ex_i,
    input  shadow_t    mem_i,
    input  shadow_t    wb_i,
    output logic [1:0] sel_o
);

    // Priority match EX > MEM > WB; unused sources read the register file.
    always_comb begin
        sel_o = FWD_RF;
        if (!used_i) begin
            sel_o = FWD_RF;
        end else if (entry_match(ex_i, src_i)) begin
            sel_o = FWD_EX;
        end else if (entry_match(mem_i, src_i)) begin
            sel_o = FWD_MEM;
        end else if (entry_match(wb_i, src_i)) begin
            sel_o = FWD_WB;
        end else begin
            sel_o = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: load-use stalls, taken-branch squash,
// memory freeze, operand forwarding selects and performance counters.
module hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid_dec_i,
    input  logic [4:0]       rs1_dec_i,
    input  logic [4:0]       rs2_dec_i,
    input  logic [4:0]       rd_dec_i,
    input  logic             uses_rs1_dec_i,
    input  logic             uses_rs2_dec_i,
    input  logic             writes_rd_dec_i,
    input  logic             is_load_dec_i,
    input  logic             branch_taken_ex_i,
    input  logic             mem_busy_i,
    output logic             stall_if_o,
    output logic             stall_dec_o,
    output logic             flush_dec_o,
    output logic             issue_dec_o,
    output logic [1:0]       fwd_rs1_sel_o,
    output logic [1:0]       fwd_rs2_sel_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [2:0]       FCNT_LOAD  = 3'(FLUSH_CYCLES - 1);
    localparam bit               MULTI_SQ   = (FLUSH_CYCLES > 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    hz_state_e        state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    shadow_t          ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic [1:0] sel1_s, sel2_s;
    logic       load_use_s, squash_s;
    logic       stall_s, flush_s, issue_s;

    hazard_fwd_sel u_fwd_rs1 (
        .src_i  (rs1_dec_i),
        .used_i (uses_rs1_dec_i),
        .ex_i   (ex_q),
        .mem_i  (mem_q),
        .wb_i   (wb_q),
        .sel_o  (sel1_s)
    );

    hazard_fwd_sel u_fwd_rs2 (
        .src_i  (rs2_dec_i),
        .used_i (uses_rs2_dec_i),
        .ex_i   (ex_q),
        .mem_i  (mem_q),
        .wb_i   (wb_q),
        .sel_o  (sel2_s)
    );

    // Control priority (freeze > squash > load-use > issue) and next-state logic.
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        stall_s     = 1'b0;
        flush_s     = 1'b0;
        issue_s     = 1'b0;

        // A load in EX can only feed a source that the EX forward path matched.
        load_use_s = instr_valid_dec_i && ex_q.ld &&
                     ((sel1_s == FWD_EX) || (sel2_s == FWD_EX));
        squash_s   = (state_q == ST_FLUSH) || branch_taken_ex_i;

        if (mem_busy_i) begin
            stall_s = 1'b1;
        end else if (squash_s) begin
            flush_s = 1'b1;
        end else if (load_use_s) begin
            stall_s = 1'b1;
        end else begin
            issue_s = instr_valid_dec_i;
        end

        if (!mem_busy_i) begin
            wb_d     = mem_q;
            mem_d    = ex_q;
            ex_d.vld = issue_s && writes_rd_dec_i;
            ex_d.rd  = rd_dec_i;
            ex_d.ld  = is_load_dec_i;

            if (flush_s && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
            if (stall_s && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end

            case (state_q)
                ST_RUN: begin
                    if (branch_taken_ex_i && MULTI_SQ) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FCNT_LOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    fcnt_d = fcnt_q - 3'd1;
                    if (fcnt_q == 3'd1) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    fcnt_d  = 3'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Drive outputs; everything reads as idle while reset is asserted.
    always_comb begin
        if (!rst_n) begin
            stall_if_o    = 1'b0;
            stall_dec_o   = 1'b0;
            flush_dec_o   = 1'b0;
            issue_dec_o   = 1'b0;
            fwd_rs1_sel_o = FWD_RF;
            fwd_rs2_sel_o = FWD_RF;
        end else begin
            stall_if_o    = stall_s;
            stall_dec_o   = stall_s;
            flush_dec_o   = flush_s;
            issue_dec_o   = issue_s;
            fwd_rs1_sel_o = sel1_s;
            fwd_rs2_sel_o = sel2_s;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

    // State, shadow and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            fcnt_q      <= 3'd0;
            ex_q        <= '{vld: 1'b0, rd: 5'd0, ld: 1'b0};
            mem_q       <= '{vld: 1'b0, rd: 5'd0, ld: 1'b0};
            wb_q        <= '{vld: 1'b0, rd: 5'd0, ld: 1'b0};
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random
// traffic compared against a history-based reference model.
module tb_hazard_ctrl;

    localparam int FC   = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          instr_valid_dec_i;
    logic [4:0]    rs1_dec_i, rs2_dec_i, rd_dec_i;
    logic          uses_rs1_dec_i, uses_rs2_dec_i, writes_rd_dec_i, is_load_dec_i;
    logic          branch_taken_ex_i, mem_busy_i;
    logic          stall_if_o, stall_dec_o, flush_dec_o, issue_dec_o;
    logic [1:0]    fwd_rs1_sel_o, fwd_rs2_sel_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instr_valid_dec_i (instr_valid_dec_i),
        .rs1_dec_i         (rs1_dec_i),
        .rs2_dec_i         (rs2_dec_i),
        .rd_dec_i          (rd_dec_i),
        .uses_rs1_dec_i    (uses_rs1_dec_i),
        .uses_rs2_dec_i    (uses_rs2_dec_i),
        .writes_rd_dec_i   (writes_rd_dec_i),
        .is_load_dec_i     (is_load_dec_i),
        .branch_taken_ex_i (branch_taken_ex_i),
        .mem_busy_i        (mem_busy_i),
        .stall_if_o        (stall_if_o),
        .stall_dec_o       (stall_dec_o),
        .flush_dec_o       (flush_dec_o),
        .issue_dec_o       (issue_dec_o),
        .fwd_rs1_sel_o     (fwd_rs1_sel_o),
        .fwd_rs2_sel_o     (fwd_rs2_sel_o),
        .stall_cnt_o       (stall_cnt_o),
        .flush_cnt_o       (flush_cnt_o)
    );

    // Reference model: the last three slots that left decode, newest first.
    typedef struct {bit vld; int rd; bit ld;} slot_t;
    slot_t hist[$];
    int    squash_left;
    int    m_scnt, m_fcnt;

    int total = 0;
    int bad   = 0;

    logic [3:0] last_ctrl;
    logic [1:0] last_f1, last_f2;
    int         last_scnt, last_fcnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back('{vld: 1'b0, rd: 0, ld: 1'b0});
        squash_left = 0;
        m_scnt      = 0;
        m_fcnt      = 0;
    endtask

    function automatic int exp_sel(input int src, input bit used);
        if (!used || src == 0) return 0;
        for (int i = 0; i < 3; i++)
            if (hist[i].vld && hist[i].rd == src) return i + 1;
        return 0;
    endfunction

    function automatic bit is_load_use(input bit v, input int r1, input bit u1,
                                       input int r2, input bit u2);
        bit hit1, hit2;
        hit1 = u1 && r1 != 0 && hist[0].vld && hist[0].ld && hist[0].rd == r1;
        hit2 = u2 && r2 != 0 && hist[0].vld && hist[0].ld && hist[0].rd == r2;
        return v && (hit1 || hit2);
    endfunction

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic cycle(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                         input int rd, input bit wr, input bit ld, input bit br, input bit busy);
        bit sq, lu;
        logic [3:0] ec;
        instr_valid_dec_i = v;
        rs1_dec_i = 5'(r1);  uses_rs1_dec_i = u1;
        rs2_dec_i = 5'(r2);  uses_rs2_dec_i = u2;
        rd_dec_i  = 5'(rd);  writes_rd_dec_i = wr;
        is_load_dec_i = ld;  branch_taken_ex_i = br;  mem_busy_i = busy;

        @(negedge clk);
        sq = (squash_left > 0) || br;
        lu = is_load_use(v, r1, u1, r2, u2);
        if (busy)    ec = 4'b1100;
        else if (sq) ec = 4'b0010;
        else if (lu) ec = 4'b1100;
        else         ec = {3'b000, v};

        last_ctrl = {stall_if_o, stall_dec_o, flush_dec_o, issue_dec_o};
        last_f1 = fwd_rs1_sel_o;  last_f2 = fwd_rs2_sel_o;
        last_scnt = int'(stall_cnt_o);  last_fcnt = int'(flush_cnt_o);
        check_eq("ctrl", 32'(last_ctrl), 32'(ec));
        check_eq("fwd1", 32'(last_f1), 32'(exp_sel(r1, u1)));
        check_eq("fwd2", 32'(last_f2), 32'(exp_sel(r2, u2)));
        check_eq("scnt", 32'(last_scnt), 32'(m_scnt));
        check_eq("fcnt", 32'(last_fcnt), 32'(m_fcnt));

        @(posedge clk);
        if (!busy) begin
            hist.push_front('{vld: ec[0] && wr, rd: rd, ld: ld});
            void'(hist.pop_back());
            if (sq)      m_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
            else if (lu) m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
            if (squash_left > 0) squash_left--;
            else if (br)         squash_left = FC - 1;
        end
        #1;
    endtask

    bit prev_busy, prev_br, nb, nbr;

    initial begin
        rst_n = 1'b0;
        instr_valid_dec_i = 1'b0; rs1_dec_i = 5'd0; rs2_dec_i = 5'd0; rd_dec_i = 5'd0;
        uses_rs1_dec_i = 1'b0; uses_rs2_dec_i = 1'b0; writes_rd_dec_i = 1'b0;
        is_load_dec_i = 1'b0; branch_taken_ex_i = 1'b0; mem_busy_i = 1'b0;
        model_reset();
        #12;
        check_eq("rst_ctrl", 32'({stall_if_o, stall_dec_o, flush_dec_o, issue_dec_o}), 32'd0);
        check_eq("rst_scnt", 32'(stall_cnt_o), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // lw x5 ; add x6,x5,x7 -> one bubble, then forward from MEM
        cycle(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        cycle(1, 5, 1, 7, 1, 6, 1, 0, 0, 0);
        check_eq("lu_stall", 32'(last_ctrl), 32'b1100);
        cycle(1, 5, 1, 7, 1, 6, 1, 0, 0, 0);
        check_eq("lu_sel", 32'(last_f1), 32'd2);
        check_eq("lu_cnt", 32'(last_scnt), 32'd1);

        // addi x3 ; sub x4,x3,x3 -> forward from EX, no stall
        cycle(1, 1, 1, 0, 0, 3, 1, 0, 0, 0);
        cycle(1, 3, 1, 3, 1, 4, 1, 0, 0, 0);
        check_eq("ex_fwd", 32'({last_f1, last_f2}), 32'b0101);
        check_eq("ex_issue", 32'(last_ctrl), 32'b0001);

        // x0 never forwards and never creates a load-use
        cycle(1, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        cycle(1, 0, 1, 0, 1, 1, 1, 0, 0, 0);
        check_eq("x0_sel", 32'({last_f1, last_f2}), 32'd0);
        cycle(1, 2, 1, 0, 0, 0, 1, 1, 0, 0);
        cycle(1, 0, 1, 0, 1, 2, 1, 0, 0, 0);
        check_eq("x0_lu", 32'(last_ctrl), 32'b0001);

        // taken branch squashes decode for FC cycles
        cycle(1, 1, 1, 2, 1, 7, 1, 0, 1, 0);
        check_eq("br_flush", 32'(last_ctrl), 32'b0010);
        cycle(1, 1, 1, 2, 1, 7, 1, 0, 0, 0);
        cycle(1, 1, 1, 2, 1, 7, 1, 0, 0, 0);
        cycle(1, 1, 1, 2, 1, 7, 1, 0, 0, 0);
        check_eq("br_done", 32'(last_ctrl), 32'b0001);
        check_eq("br_cnt", 32'(last_fcnt), 32'd3);

        // freeze during a load-use: stall held, nothing counted until release
        cycle(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 9, 1, 0, 0, 8, 1, 0, 0, 1);
        cycle(1, 9, 1, 0, 0, 8, 1, 0, 0, 0);
        check_eq("frz_lu", 32'(last_ctrl), 32'b1100);
        cycle(1, 9, 1, 0, 0, 8, 1, 0, 0, 0);
        check_eq("frz_sel", 32'(last_f1), 32'd2);
        check_eq("frz_cnt", 32'(last_scnt), 32'd2);

        // reset in the middle of a squash
        cycle(1, 8, 1, 0, 0, 3, 1, 0, 1, 0);
        instr_valid_dec_i = 1'b1; branch_taken_ex_i = 1'b1; rs1_dec_i = 5'd3;
        uses_rs1_dec_i = 1'b1; mem_busy_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ctrl", 32'({stall_if_o, stall_dec_o, flush_dec_o, issue_dec_o}), 32'd0);
        check_eq("mid_rst_sel", 32'(fwd_rs1_sel_o), 32'd0);
        check_eq("mid_rst_cnt", 32'({stall_cnt_o, flush_cnt_o}), 32'd0);
        model_reset();
        instr_valid_dec_i = 1'b0; branch_taken_ex_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(1, 3, 1, 8, 1, 4, 1, 0, 0, 0);
        check_eq("post_rst", 32'({last_ctrl, last_f1, last_f2}), 32'b0001_00_00);

        // random traffic; a frozen EX keeps its branch asserted
        prev_busy = 1'b0; prev_br = 1'b0;
        for (int n = 0; n < 600; n++) begin
            nb  = ($urandom_range(0, 7) == 0);
            nbr = (prev_busy && prev_br) ? 1'b1 : ($urandom_range(0, 9) == 0);
            cycle($urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, nbr, nb);
            prev_busy = nb; prev_br = nbr;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
